fifo_stream_reader: RTL and testbench

Read-side drain engine for the synchronous `fifo` block. It issues `rd_en` pops against the FIFO's one-cycle registered read port and captures the returned `rd_data`. It re-times the data into a valid/ready output stream through a 2-entry skid buffer, so a downstream consumer can stall at any cycle without losing words. It also frames the stream into fixed-length bursts with a `o_last` marker and counts delivered words.

---
 rtl/fifo_pkg.sv | 21 ++
 rtl/skid_buf2.sv | 69 ++++++
 rtl/fifo_stream_reader.sv | 87 ++++++++
 tb/tb_fifo_stream_reader.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : fifo_pkg
//  Brief    : Shared defaults, types and helpers for the FIFO read-side logic.
//  Revision : 1.0  initial release
// ============================================================================
package fifo_pkg;

  localparam int unsigned DEF_WIDTH     = 32;
  localparam int unsigned DEF_BURST_LEN = 16;

  // Skid-buffer occupancy, 0..2 entries
  typedef logic [1:0] occ_t;

  // Width of the in-burst position counter; never narrower than one bit
  function automatic int unsigned beat_width(input int unsigned burst_len);
    return (burst_len <= 1) ? 1 : $clog2(burst_len);
  endfunction

endpackage
`default_nettype wire

// File: rtl/skid_buf2.sv
`default_nettype none
// ============================================================================
//  Module   : skid_buf2
//  Brief    : Two-entry register buffer. Entry 0 is always the head; entry 1
//             holds the second-oldest word. Push and pop may coincide.
//  Revision : 1.0  initial release
// ============================================================================
module skid_buf2
  import fifo_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic             clk_i,
  input  logic             arst_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] data_i,
  output occ_t             occ_o,
  output logic [WIDTH-1:0] head_o
);

  occ_t             occ_q, occ_d;
  logic [WIDTH-1:0] ent0_q, ent0_d;
  logic [WIDTH-1:0] ent1_q, ent1_d;

  // Next-state: pop shifts entry 1 into the head; a push lands in the first
  // free slot after any simultaneous pop, which keeps FIFO order.
  always_comb begin
    occ_d  = occ_q;
    ent0_d = ent0_q;
    ent1_d = ent1_q;
    if (push_i && pop_i) begin
      if (occ_q == 2'd2) begin
        ent0_d = ent1_q;
        ent1_d = data_i;
      end else begin
        ent0_d = data_i;
      end
    end else if (pop_i) begin
      ent0_d = ent1_q;
      occ_d  = occ_q - 2'd1;
    end else if (push_i) begin
      if (occ_q == 2'd0) begin
        ent0_d = data_i;
      end else begin
        ent1_d = data_i;
      end
      occ_d = occ_q + 2'd1;
    end
  end

  // Buffer storage and occupancy registers
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      occ_q  <= 2'd0;
      ent0_q <= '0;
      ent1_q <= '0;
    end else begin
      occ_q  <= occ_d;
      ent0_q <= ent0_d;
      ent1_q <= ent1_d;
    end
  end

  assign occ_o  = occ_q;
  assign head_o = ent0_q;

endmodule
`default_nettype wire

// File: rtl/fifo_stream_reader.sv
`default_nettype none
// ============================================================================
//  Module   : fifo_stream_reader
//  Brief    : Drains a synchronous FIFO with a one-cycle read port into a
//             valid/ready stream via a 2-entry skid buffer, framing the
//             stream into fixed-length bursts and counting delivered words.
//  Revision : 1.0  initial release
// ============================================================================
module fifo_stream_reader
  import fifo_pkg::*;
#(
  parameter int unsigned WIDTH     = DEF_WIDTH,
  parameter int unsigned BURST_LEN = DEF_BURST_LEN
) (
  input  logic             i_clk,
  input  logic             arst,
  input  logic             i_enable,
  input  logic             i_fifo_empty,
  output logic             o_fifo_rd_en,
  input  logic [WIDTH-1:0] i_fifo_rd_data,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_data,
  output logic             o_last,
  output logic [31:0]      o_word_count
);

  localparam int unsigned         BEAT_W    = beat_width(BURST_LEN);
  localparam logic [BEAT_W-1:0]   BEAT_LAST = BEAT_W'(BURST_LEN - 1);

  occ_t              occ;
  logic              inflight_q;
  logic [BEAT_W-1:0] beat_q, beat_d;
  logic [31:0]       count_q;
  logic              xfer;
  logic [2:0]        pending;

  assign o_valid = (occ != 2'd0);
  assign xfer    = o_valid && i_ready;

  // Words that will occupy the buffer after this edge if no new pop is made.
  // xfer implies occ >= 1, so the subtraction cannot underflow.
  assign pending = {1'b0, occ} + {2'b00, inflight_q} - {2'b00, xfer};

  // Reset gating keeps the pop request low while the FIFO is being cleared.
  assign o_fifo_rd_en = !arst && i_enable && !i_fifo_empty && (pending < 3'd2);

  assign o_last       = o_valid && (beat_q == BEAT_LAST);
  assign o_word_count = count_q;

  skid_buf2 #(
    .WIDTH (WIDTH)
  ) u_skid (
    .clk_i  (i_clk),
    .arst_i (arst),
    .push_i (inflight_q),
    .pop_i  (xfer),
    .data_i (i_fifo_rd_data),
    .occ_o  (occ),
    .head_o (o_data)
  );

  // Burst position advances on every delivered word and wraps at the burst end
  always_comb begin
    beat_d = beat_q;
    if (xfer) begin
      beat_d = (beat_q == BEAT_LAST) ? '0 : beat_q + 1'b1;
    end
  end

  // In-flight flag, burst position and delivered-word counter
  always_ff @(posedge i_clk or posedge arst) begin
    if (arst) begin
      inflight_q <= 1'b0;
      beat_q     <= '0;
      count_q    <= '0;
    end else begin
      inflight_q <= o_fifo_rd_en;
      beat_q     <= beat_d;
      if (xfer) begin
        count_q <= count_q + 32'd1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fifo_stream_reader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fifo_stream_reader
//  Brief    : Self-checking bench for fifo_stream_reader. A queue-based FIFO
//             model feeds the DUT; a second queue holds words popped but not
//             yet delivered, which is the expected output order.
//  Revision : 1.0  initial release
// ============================================================================
module tb_fifo_stream_reader;

  localparam int unsigned W  = 32;
  localparam int unsigned BL = 4;

  logic          clk = 1'b0;
  logic          arst = 1'b1;
  logic          i_enable = 1'b0;
  logic          i_fifo_empty = 1'b1;
  logic          o_fifo_rd_en;
  logic [W-1:0]  i_fifo_rd_data = '0;
  logic          o_valid;
  logic          i_ready = 1'b0;
  logic [W-1:0]  o_data;
  logic          o_last;
  logic [31:0]   o_word_count;

  fifo_stream_reader #(
    .WIDTH     (W),
    .BURST_LEN (BL)
  ) dut (
    .i_clk          (clk),
    .arst           (arst),
    .i_enable       (i_enable),
    .i_fifo_empty   (i_fifo_empty),
    .o_fifo_rd_en   (o_fifo_rd_en),
    .i_fifo_rd_data (i_fifo_rd_data),
    .o_valid        (o_valid),
    .i_ready        (i_ready),
    .o_data         (o_data),
    .o_last         (o_last),
    .o_word_count   (o_word_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [W-1:0] fifo_q[$];
  logic [W-1:0] exp_q[$];
  logic         wr_en = 1'b0;
  logic [W-1:0] wr_data = '0;

  int cyc = 0;
  int delivered = 0;
  int popped = 0;
  int ph_del, ph_rd, ph_last;
  int first_rd_cyc, first_v_cyc, first_x_cyc, last_x_cyc;
  logic         prev_stall = 1'b0;
  logic [W-1:0] prev_data = '0;
  logic         prev_last = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic phase_start();
    ph_del = 0; ph_rd = 0; ph_last = 0;
    first_rd_cyc = -1; first_v_cyc = -1; first_x_cyc = -1; last_x_cyc = -1;
  endtask

  task automatic preload(input int n, input logic [W-1:0] base);
    for (int k = 0; k < n; k++) fifo_q.push_back(base + W'(k));
    i_fifo_empty = (fifo_q.size() == 0);
  endtask

  // One clock cycle: sample at the falling edge, update the FIFO model just
  // after the rising edge. Entered and left at rising edge + 1.
  task automatic tick();
    logic         rd_s, v_s, l_s;
    logic [W-1:0] d_s;
    @(negedge clk);
    rd_s = o_fifo_rd_en; v_s = o_valid; d_s = o_data; l_s = o_last;
    if (prev_stall) begin
      check("stall_data", d_s, prev_data);
      check("stall_last", l_s, prev_last);
    end
    if (rd_s) begin
      check("rd_when_empty", fifo_q.size() != 0, 1'b1);
      ph_rd++;
      if (first_rd_cyc < 0) first_rd_cyc = cyc;
    end
    if (v_s) begin
      if (first_v_cyc < 0) first_v_cyc = cyc;
      if (exp_q.size() == 0) begin
        check("spurious_valid", v_s, 1'b0);
      end else begin
        check("data", d_s, exp_q[0]);
        check("last", l_s, (delivered % BL) == (BL - 1));
        if (i_ready) begin
          void'(exp_q.pop_front());
          delivered++; ph_del++;
          if (l_s) ph_last++;
          if (first_x_cyc < 0) first_x_cyc = cyc;
          last_x_cyc = cyc;
        end
      end
    end
    prev_stall = v_s && !i_ready;
    prev_data  = d_s;
    prev_last  = l_s;
    cyc++;
    @(posedge clk);
    #1;
    if (rd_s && fifo_q.size() != 0) begin
      i_fifo_rd_data = fifo_q.pop_front();
      exp_q.push_back(i_fifo_rd_data);
      popped++;
    end
    if (wr_en) fifo_q.push_back(wr_data);
    wr_en = 1'b0;
    i_fifo_empty = (fifo_q.size() == 0);
  endtask

  task automatic run_until_deliv(input int n, input int budget);
    int b = 0;
    while (ph_del < n && b < budget) begin
      tick();
      b++;
    end
    if (ph_del < n) check("deliv_timeout", ph_del, n);
  endtask

  task automatic check_reset_outputs();
    check("rst_rd_en", o_fifo_rd_en, 1'b0);
    check("rst_valid", o_valid, 1'b0);
    check("rst_data", o_data, '0);
    check("rst_last", o_last, 1'b0);
    check("rst_count", o_word_count, '0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int snap;
    // Reset state
    i_enable = 1'b1;
    #3;
    check_reset_outputs();
    @(posedge clk); #1;
    arst = 1'b0;

    // Streaming: 8 words, consumer always ready
    phase_start();
    i_ready = 1'b1;
    preload(8, 32'h1);
    run_until_deliv(8, 30);
    check("first_latency", first_v_cyc - first_rd_cyc, 2);
    check("back_to_back", last_x_cyc - first_x_cyc, 7);
    check("stream_count", o_word_count, 8);
    check("stream_lasts", ph_last, 2);

    // Framing: 10 more words, last on the 4th and 8th of them
    phase_start();
    preload(10, 32'h100);
    run_until_deliv(10, 30);
    check("frame_lasts", ph_last, 2);
    check("frame_count", o_word_count, 18);
    check("frame_beat", delivered % BL, 2);

    // Backpressure: stall for 5 cycles after word 2
    phase_start();
    preload(6, 32'h200);
    run_until_deliv(2, 20);
    i_ready = 1'b0;
    snap = ph_rd;
    repeat (5) tick();
    check("stall_pops_le1", (ph_rd - snap) <= 1, 1'b1);
    check("stall_no_deliv", ph_del, 2);
    i_ready = 1'b1;
    run_until_deliv(6, 30);
    check("bp_count", o_word_count, 24);

    // Empty and enable: 3 words, disable with the last pop in flight
    phase_start();
    preload(3, 32'h300);
    begin
      int b = 0;
      while (ph_rd < 3 && b < 10) begin tick(); b++; end
    end
    check("ee_pops", ph_rd, 3);
    i_enable = 1'b0;
    preload(2, 32'h310);
    snap = ph_rd;
    repeat (6) tick();
    check("ee_no_pop_disabled", ph_rd - snap, 0);
    check("ee_inflight_deliv", ph_del, 3);
    check("ee_valid_low", o_valid, 1'b0);
    i_enable = 1'b1;
    run_until_deliv(5, 20);

    // Random traffic against the reference queues
    phase_start();
    for (int c = 0; c < 500; c++) begin
      wr_en    = ($urandom_range(0, 1) == 1);
      wr_data  = $urandom;
      i_ready  = ($urandom_range(0, 1) == 1);
      i_enable = ($urandom_range(0, 7) != 0);
      tick();
    end
    wr_en = 1'b0; i_ready = 1'b1; i_enable = 1'b1;
    begin
      int b = 0;
      while ((fifo_q.size() != 0 || exp_q.size() != 0) && b < 400) begin tick(); b++; end
    end
    repeat (2) tick();
    check("rand_drained", exp_q.size(), 0);
    check("rand_valid_low", o_valid, 1'b0);
    check("rand_count_deliv", o_word_count, delivered);
    check("rand_count_popped", o_word_count, popped);

    // Reset mid-burst with a full buffer
    phase_start();
    preload(6, 32'h400);
    run_until_deliv(1, 10);
    i_ready = 1'b0;
    repeat (4) tick();
    check("occ_before_reset", exp_q.size(), 2);
    #2;
    arst = 1'b1;
    #1;
    check_reset_outputs();
    fifo_q.delete(); exp_q.delete();
    delivered = 0; popped = 0; prev_stall = 1'b0;
    i_fifo_empty = 1'b1;
    repeat (2) tick();
    arst = 1'b0;
    phase_start();
    i_ready = 1'b1;
    preload(3, 32'h500);
    run_until_deliv(3, 20);
    check("post_reset_count", o_word_count, 3);
    check("post_reset_lasts", ph_last, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
